// File: rtl/data_sram_resp_pkg.sv
// Shared types and defaults for the data-SRAM responder (wait states enabled by DSRAM_WAIT_EN).
package data_sram_resp_pkg;

  localparam int unsigned DSRAM_ADDR_W      = 12;
  localparam int unsigned DSRAM_WAIT_CYCLES = 2;
  localparam int unsigned DATA_W            = 32;
  localparam int unsigned LANES             = DATA_W / 8;
  // Bit of the pipeline stall bus driven by this block's stallreq.
  localparam int unsigned STALL_REQ_MEM     = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dsram_state_e;

  // Wait counter width; never zero so WAIT_CYCLES=0 still elaborates.
  function automatic int unsigned cnt_width(input int unsigned wait_cycles);
    int unsigned w;
    w = $clog2(wait_cycles + 1);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/dsram_bank.sv
// 2^ADDR_W x 32 byte-lane-writable array with a registered, enabled read port.
module dsram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = DSRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              clr,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)      rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[addr];
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: range check, optional wait-state FSM (DSRAM_WAIT_EN), registered read data.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = DSRAM_ADDR_W,
  parameter int unsigned WAIT_CYCLES = DSRAM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [LANES-1:0]  data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              addr_err,
  output logic              stallreq
);

  logic in_range_c;
  logic release_c;
  logic fire_c;
  logic unused_c;

  assign in_range_c = (data_sram_addr[31:ADDR_W+2] == '0);
  assign fire_c     = data_sram_en & release_c;

`ifdef DSRAM_WAIT_EN
  localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

  dsram_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stall_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stall for WAIT_CYCLES cycles, then release one access; a dropped request aborts.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    release_c = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (data_sram_en) begin
            if (WAIT_CYCLES == 0) begin
              release_c = 1'b1;
            end else begin
              stall_c   = 1'b1;
              cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
              state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!data_sram_en) begin
            state_nxt = ST_IDLE;
          end else if (cnt != '0) begin
            stall_c = 1'b1;
            cnt_nxt = cnt - CNT_W'(1);
          end else begin
            release_c = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign stallreq = stall_c;
  assign unused_c = ^data_sram_addr[1:0];
`else
  assign release_c = 1'b1;
  assign stallreq  = 1'b0;
  assign unused_c  = ^{data_sram_addr[1:0], WAIT_CYCLES[0]};
`endif

  dsram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .re    (fire_c & in_range_c & (data_sram_wen == '0)),
    .clr   (fire_c & ~in_range_c),
    .we    ((fire_c & in_range_c) ? data_sram_wen : '0),
    .addr  (data_sram_addr[ADDR_W+1:2]),
    .wdata (data_sram_wdata),
    .rdata (data_sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst)         addr_err <= 1'b0;
    else if (fire_c) addr_err <= ~in_range_c;
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp with a behavioural memory model; covers DSRAM_WAIT_EN when defined.
module tb_data_sram_resp;

  localparam int unsigned AW = 12;
  localparam int unsigned WC = 2;
`ifdef DSRAM_WAIT_EN
  localparam int unsigned EFF_WAIT = WC;
`else
  localparam int unsigned EFF_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        addr_err;
  logic        stallreq;

  int total = 0;
  int bad = 0;

  logic [31:0] mdl [int];
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  data_sram_resp #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .addr_err        (addr_err),
    .stallreq        (stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%08h expected=%08h t=%0t", nm, act, exp, $time);
    end
  endtask

  // What one serviced access does to the model, straight from the access rules.
  task automatic model_apply(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int idx;
    logic [31:0] cur;
    idx = int'(a[AW+1:2]);
    if ((a >> (AW + 2)) != 0) begin
      exp_rdata = 32'h0;
      exp_err   = 1'b1;
    end else begin
      exp_err = 1'b0;
      cur = mdl.exists(idx) ? mdl[idx] : 32'h0;
      if (w != 4'h0) begin
        for (int i = 0; i < 4; i++)
          if (w[i]) cur[8*i +: 8] = d[8*i +: 8];
        mdl[idx] = cur;
      end else begin
        exp_rdata = cur;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the release edge with en low.
  task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = 1'b1; wen = w; addr = a; wdata = d;
    for (int k = 0; k < int'(EFF_WAIT); k++) begin
      @(negedge clk);
      check("stall_hi", 32'(stallreq), 32'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stall_release", 32'(stallreq), 32'h0);
    @(posedge clk);
    model_apply(w, a, d);
    #1;
    en = 1'b0; wen = '0;
  endtask

  // Continuous comparison of registered outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("rdata", rdata, exp_rdata);
      check("addr_err", 32'(addr_err), 32'(exp_err));
      if (!en) check("stall_idle", 32'(stallreq), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_reset", 32'(stallreq), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_err", 32'(addr_err), 32'h0);
    @(posedge clk); #1;

    access(4'h0, 32'h0000_0000, 32'h0);
    @(negedge clk);
    check("rd0_lit", rdata, 32'h0);
    check("rd0_err_lit", 32'(addr_err), 32'h0);
    @(posedge clk); #1;

    access(4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    access(4'h0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    check("full_word_lit", rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    access(4'h1, 32'h0000_0010, 32'h0000_00AA);
    access(4'h0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    check("lane0_lit", rdata, 32'hDEAD_BEAA);
    @(posedge clk); #1;

    access(4'hC, 32'h0000_0010, 32'h1234_0000);
    access(4'h0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    check("lane23_lit", rdata, 32'h1234_BEAA);
    @(posedge clk); #1;

    // A write must leave rdata holding the last read.
    access(4'hF, 32'h0000_0014, 32'h0BAD_F00D);
    @(negedge clk);
    check("write_hold_lit", rdata, 32'h1234_BEAA);
    @(posedge clk); #1;
    access(4'h0, 32'h0000_0014, 32'h0);
    @(negedge clk);
    check("rd14_lit", rdata, 32'h0BAD_F00D);
    @(posedge clk); #1;

    access(4'h0, 32'h0001_0000, 32'h0);
    @(negedge clk);
    check("oor_rdata_lit", rdata, 32'h0);
    check("oor_err_lit", 32'(addr_err), 32'h1);
    @(posedge clk); #1;
    access(4'hF, 32'h0001_0000, 32'h5555_5555);
    access(4'hF, 32'h0000_4000, 32'h6666_6666);
    access(4'h0, 32'h0000_0000, 32'h0);
    @(negedge clk);
    check("oor_nowrite_lit", rdata, 32'h0);
    check("oor_cleared_lit", 32'(addr_err), 32'h0);
    @(posedge clk); #1;

    // Back-to-back reads with low address bits set (ignored).
    access(4'h0, 32'h0000_0013, 32'h0);
    access(4'h0, 32'h0000_0015, 32'h0);
    @(negedge clk);
    check("b2b_lit", rdata, 32'h0BAD_F00D);
    @(posedge clk); #1;

    // Top in-range word.
    access(4'hF, 32'h0000_3FFC, 32'hA5A5_5A5A);
    access(4'h0, 32'h0000_0010, 32'h0);
    access(4'h0, 32'h0000_3FFC, 32'h0);
    @(negedge clk);
    check("top_word_lit", rdata, 32'hA5A5_5A5A);
    @(posedge clk); #1;

`ifdef DSRAM_WAIT_EN
    // Request withdrawn during WAIT: no access, stall drops.
    en = 1'b1; wen = 4'hF; addr = 32'h0000_0010; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("flush_stall_hi", 32'(stallreq), 32'h1);
    @(posedge clk); #1;
    en = 1'b0; wen = '0;
    @(negedge clk);
    check("flush_stall_lo", 32'(stallreq), 32'h0);
    @(posedge clk); #1;
    access(4'h0, 32'h0000_0010, 32'h0);
    @(negedge clk);
    check("flush_nowrite_lit", rdata, 32'h1234_BEAA);
    @(posedge clk); #1;

    // Reset while a write to 0x20 is stalled.
    en = 1'b1; wen = 4'hF; addr = 32'h0000_0020; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("rstwait_stall_hi", 32'(stallreq), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    exp_rdata = 32'h0;
    exp_err   = 1'b0;
    #1;
    check("rstwait_stall_lo", 32'(stallreq), 32'h0);
    rst = 1'b0; en = 1'b0; wen = '0;
    @(negedge clk);
    check("rstwait_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    access(4'h0, 32'h0000_0020, 32'h0);
    @(negedge clk);
    check("rstwait_old_lit", rdata, 32'h0);
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Data-memory responder on the load/store side of the five-stage pipeline. It accepts the data-SRAM request (enable, byte write enables, address, write data) issued in EX and returns read data registered one cycle later, where MEM consumes it as `data_sram_rdata`. It flags out-of-range accesses. An optional wait-state engine raises a stall request so the pipeline freezes EX/MEM while a slow access completes.

## Interface
- `ADDR_W`, 12 — word-address bits; array depth 2^ADDR_W words of 32 bits
- `WAIT_CYCLES`, 2 — stall cycles per access; only meaningful with `DSRAM_WAIT_EN`
- `clk` in 1 — clock, all state on rising edge
- `rst` in 1 — reset rst, synchronous, active-high; clock clk
- `data_sram_en` in 1 — request valid this cycle
- `data_sram_wen` in 4 — byte-lane write enables, bit i → bits [8i+7:8i]; 0 = read
- `data_sram_addr` in 32 — byte address; bits [1:0] ignored
- `data_sram_wdata` in 32 — store data, lane-aligned by EX
- `data_sram_rdata` out 32 — read word, registered
- `addr_err` out 1 — registered; 1 when the access just serviced had addr[31:ADDR_W+2] ≠ 0
- `stallreq` out 1 — combinational stall request to the stall controller

## Operation
- Index = `data_sram_addr[ADDR_W+1:2]`. Upper bits must be zero. Otherwise the access is suppressed: no write, rdata forced to 0, addr_err=1 for one cycle.
- Access fires when `data_sram_en`=1 and, with waits enabled, the FSM is in its release cycle.
- Write (wen≠0): only the enabled lanes are updated. rdata holds its previous value. addr_err=0 unless out of range.
- Read (wen=0): rdata ← mem[index] on the next edge.
- en=0: no access. rdata and addr_err hold their values.
- Read-during-write cannot occur, because there is one port and one request per cycle.
- Memory contents are not reset. Simulation initialises them to 0.
- Reset values: rdata=0, addr_err=0, stallreq=0, FSM=IDLE, counter=0.

## Timing
- Without waits: request in cycle N → rdata/addr_err valid in N+1. stallreq stays at 0.
- With waits, FSM states are IDLE and WAIT:
  - IDLE & en: stallreq=1, cnt←WAIT_CYCLES-1, go to WAIT. No access.
  - WAIT & cnt≠0: stallreq=1, cnt←cnt-1.
  - WAIT & cnt=0: stallreq=0, access fires (release cycle), go to IDLE.
  - Total stall = WAIT_CYCLES cycles. rdata is valid the cycle after release.
- The requester holds en/wen/addr/wdata stable while stallreq=1. The block samples them only in the release cycle.
- Back-to-back: a request present in the cycle after release starts a new IDLE→WAIT sequence.
- en dropped while in WAIT (e.g. flush): return to IDLE next cycle with stallreq=0 and no access.
- WAIT_CYCLES=0 behaves identically to the no-wait build.
- rst in WAIT: FSM→IDLE and stallreq→0 on that edge. The pending write is discarded.

## Configuration
- `DSRAM_WAIT_EN` defined: the FSM, the counter (width $clog2(WAIT_CYCLES+1)) and stallreq are built as above.
- `DSRAM_WAIT_EN` undefined: no FSM, single-cycle access, stallreq tied to 0, WAIT_CYCLES ignored.

## Structure
- Shared `lib/defines.vh` holds: `DSRAM_ADDR_W` default, `DSRAM_WAIT_CYCLES` default, and stall-bus bit index `StallReqMem` used by the stall controller.
- One sub-module, `dsram_bank`: a 2^ADDR_W×32 array with 4 byte-lane write enables and a registered read port with read-enable. The top module holds the range check, the FSM and the output muxing.

## Test plan
- Reset, then read addr 0x0000_0000 → rdata=0 and addr_err=0 the next cycle. stallreq stays 0 through reset.
- Write 0xDEADBEEF to 0x10 with wen=4'hF, then read 0x10 → rdata=0xDEADBEEF one cycle after the read.
- Write 0x000000AA to 0x10 with wen=4'h1 over the prior value, then read → 0xDEADBEAA. Repeat with wen=4'hC and wdata 0x12340000 → 0x1234BEAA.
- Read 0x0001_0000 (ADDR_W=12) → rdata=0, addr_err=1 for one cycle. A write to the same address leaves mem[0] unchanged.
- `DSRAM_WAIT_EN`, WAIT_CYCLES=2, read 0x10 held stable → stallreq=1 for exactly 2 cycles, then 0 in the release cycle. rdata valid the following cycle. A back-to-back second read re-stalls 2 cycles.
- `DSRAM_WAIT_EN`: assert rst during WAIT of a write to 0x20 → stallreq=0 and FSM=IDLE after the edge. A later read of 0x20 returns the old value.
